// File: rtl/e203_ifu_pkg.sv
// Shared types and sizing helpers for the IFU flush-response logic.
package e203_ifu_pkg;

    // Default number of fetch transactions that may be in flight at once.
    localparam int OUTS_DEPTH_DEF = 2;

    // Redirect request state: nothing pending, or a redirect waiting for the fetch path.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } flush_st_e;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/e203_ifu_outs_cnt.sv
// Up/down transaction counter with a parallel load. Loading has priority
// over counting. Overflow beyond DEPTH and underflow below zero are protocol
// violations by the surrounding logic and are flagged by assertions.
module e203_ifu_outs_cnt
    import e203_ifu_pkg::*;
#(
    parameter int DEPTH = OUTS_DEPTH_DEF,
    parameter int W     = cnt_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise a simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

`ifndef SYNTHESIS
    // Incrementing a full counter without a matching decrement is illegal.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(!load_i && inc_i && !dec_i && (cnt_q == W'(DEPTH))));

    // A decrement can never happen while nothing is counted, even if an
    // increment arrives in the same cycle (a response cannot belong to a
    // request accepted in that very cycle).
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(!load_i && dec_i && (cnt_q == '0)));
`endif

endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// IFU-side responder for the EXU pipeline-flush interface. Accepts a flush,
// forms the redirect PC, issues one redirect fetch request toward the fetch
// path, and tracks in-flight fetches so that responses to requests issued
// before a flush are flagged for discard.
module e203_ifu_flush_rsp
    import e203_ifu_pkg::*;
#(
    parameter int PC_SIZE      = 32,
    parameter int OUTS_DEPTH   = OUTS_DEPTH_DEF,
    parameter bit TIMING_BOOST = 1'b0,
    localparam int CNT_W       = cnt_w(OUTS_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               pipe_flush_req,
    output logic               pipe_flush_ack,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
    input  logic [PC_SIZE-1:0] pipe_flush_pc,

    output logic               redir_valid,
    input  logic               redir_ready,
    output logic [PC_SIZE-1:0] redir_pc,

    output logic               seq_fetch_block,

    input  logic               fetch_hsk,
    input  logic               rsp_hsk,
    output logic               rsp_drop,
    output logic [CNT_W-1:0]   outs_cnt
);

    flush_st_e          state_q;
    flush_st_e          state_d;
    logic [PC_SIZE-1:0] redir_pc_q;
    logic [PC_SIZE-1:0] redir_pc_d;
    logic               ack_q;

    logic               flush_hsk;
    logic               redir_hsk;
    logic [PC_SIZE-1:0] tgt_sum;
    logic [PC_SIZE-1:0] tgt_pc;

    logic [CNT_W-1:0]   outs_cnt_q;
    logic [CNT_W-1:0]   outs_cnt_nxt;
    logic [CNT_W-1:0]   drop_cnt_q;
    logic               drop_dec;

    // ------------------------------------------------------------------
    // Flush acceptance. The ack is a plain register that comes up one
    // clock after reset release and stays high, so the reset net is never
    // used as data and the flush is accepted in the cycle it is raised.
    // ------------------------------------------------------------------

    // Ack register: low in reset, high from the first clock afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= 1'b1;
        end
    end

    assign pipe_flush_ack = ack_q;
    assign flush_hsk      = pipe_flush_req & pipe_flush_ack;

    // ------------------------------------------------------------------
    // Redirect target. The sum wraps modulo 2^PC_SIZE; in boost mode the
    // EXU already computed the target and the adder result is ignored.
    // ------------------------------------------------------------------
    assign tgt_sum = pipe_flush_add_op1 + pipe_flush_add_op2;
    assign tgt_pc  = TIMING_BOOST ? pipe_flush_pc : tgt_sum;

    // ------------------------------------------------------------------
    // Redirect request FSM. A new flush always overwrites the pending
    // target; if the old redirect is consumed in the same cycle, the new
    // one is presented on the following cycle.
    // ------------------------------------------------------------------
    assign redir_valid = (state_q == PEND);
    assign redir_hsk   = redir_valid & redir_ready;
    assign redir_pc    = redir_pc_q;

    // Next-state and next-target selection for the redirect request.
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            IDLE: begin
                if (flush_hsk) begin
                    state_d    = PEND;
                    redir_pc_d = tgt_pc;
                end
            end
            PEND: begin
                if (flush_hsk) begin
                    state_d    = PEND;
                    redir_pc_d = tgt_pc;
                end else if (redir_hsk) begin
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                redir_pc_d = redir_pc_q;
            end
        endcase
    end

    // Redirect state and target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Sequential fetch must wait while a flush is arriving or a redirect
    // has not yet been taken by the fetch path.
    assign seq_fetch_block = pipe_flush_req | redir_valid;

    // ------------------------------------------------------------------
    // Outstanding and stale-response tracking.
    // ------------------------------------------------------------------

    // Outstanding count as it will be after this cycle's handshakes; on a
    // flush, every one of those transactions becomes stale.
    always_comb begin
        outs_cnt_nxt = outs_cnt_q;
        if (fetch_hsk && !rsp_hsk) begin
            outs_cnt_nxt = outs_cnt_q + CNT_W'(1);
        end else if (rsp_hsk && !fetch_hsk) begin
            outs_cnt_nxt = outs_cnt_q - CNT_W'(1);
        end
    end

    e203_ifu_outs_cnt #(
        .DEPTH      (OUTS_DEPTH),
        .W          (CNT_W)
    ) u_outs_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (fetch_hsk),
        .dec_i      (rsp_hsk),
        .cnt_o      (outs_cnt_q)
    );

    // Stale responses are always the oldest ones in flight, so a simple
    // count of how many of the next responses to discard is enough. A
    // re-flush reloads the count, which already includes older stale ones.
    assign drop_dec = rsp_hsk & (drop_cnt_q != '0);

    e203_ifu_outs_cnt #(
        .DEPTH      (OUTS_DEPTH),
        .W          (CNT_W)
    ) u_drop_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (flush_hsk),
        .load_val_i (outs_cnt_nxt),
        .inc_i      (1'b0),
        .dec_i      (drop_dec),
        .cnt_o      (drop_cnt_q)
    );

    assign rsp_drop = (drop_cnt_q != '0);
    assign outs_cnt = outs_cnt_q;

`ifndef SYNTHESIS
    // While a redirect waits for the fetch path, its target must not move
    // unless a newer flush replaces it.
    a_redir_pc_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (redir_valid && !redir_ready && !flush_hsk) |=> (redir_pc == $past(redir_pc)));

    // Stale entries can never exceed what is actually in flight.
    a_drop_le_outs : assert property (@(posedge clk) disable iff (!rst_n)
        (drop_cnt_q <= outs_cnt_q));
`endif

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Self-checking bench for e203_ifu_flush_rsp. Two instances share stimulus:
// one with the adder path and one with the precomputed-PC path. A reference
// model tags every in-flight fetch with the flush epoch it was issued in.
module tb_e203_ifu_flush_rsp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, ready, fetch, rsp;
    logic [31:0] op1, op2, fpc;

    logic        ack, rv, sfb, drop;
    logic [31:0] rpc;
    logic [1:0]  ocnt;
    logic        b_ack, b_rv, b_sfb, b_drop;
    logic [31:0] b_rpc;
    logic [1:0]  b_ocnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          q_ep[$];
    int          epoch;
    bit          m_pend;
    logic [31:0] m_pc, m_bpc;
    int          dut_hsk;

    always #5 clk = ~clk;

    e203_ifu_flush_rsp #(.PC_SIZE(32), .OUTS_DEPTH(2), .TIMING_BOOST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_flush_req(req), .pipe_flush_ack(ack),
        .pipe_flush_add_op1(op1), .pipe_flush_add_op2(op2), .pipe_flush_pc(fpc),
        .redir_valid(rv), .redir_ready(ready), .redir_pc(rpc),
        .seq_fetch_block(sfb), .fetch_hsk(fetch), .rsp_hsk(rsp),
        .rsp_drop(drop), .outs_cnt(ocnt)
    );

    e203_ifu_flush_rsp #(.PC_SIZE(32), .OUTS_DEPTH(2), .TIMING_BOOST(1'b1)) dut_boost (
        .clk(clk), .rst_n(rst_n),
        .pipe_flush_req(req), .pipe_flush_ack(b_ack),
        .pipe_flush_add_op1(op1), .pipe_flush_add_op2(op2), .pipe_flush_pc(fpc),
        .redir_valid(b_rv), .redir_ready(ready), .redir_pc(b_rpc),
        .seq_fetch_block(b_sfb), .fetch_hsk(fetch), .rsp_hsk(rsp),
        .rsp_drop(b_drop), .outs_cnt(b_ocnt)
    );

    task automatic model_reset();
        q_ep.delete();
        epoch  = 0;
        m_pend = 1'b0;
        m_pc   = '0;
        m_bpc  = '0;
    endtask

    function automatic bit exp_drop();
        return (q_ep.size() > 0) && (q_ep[0] < epoch);
    endfunction

    // Drive one cycle of inputs half a period before the active edge.
    task automatic drive(input bit f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input bit rdy, input bit fh, input bit rh);
        @(negedge clk);
        req = f; op1 = a; op2 = b; fpc = p; ready = rdy; fetch = fh; rsp = rh;
        #1;
        if (rv && ready) dut_hsk++;
    endtask

    // Take the active edge, advance the model with the driven inputs, settle.
    task automatic advance();
        @(posedge clk);
        if (rsp && q_ep.size() > 0) void'(q_ep.pop_front());
        if (fetch) q_ep.push_back(epoch);
        if (req) begin
            epoch++;
            m_pend = 1'b1;
            m_pc   = op1 + op2;
            m_bpc  = fpc;
        end else if (m_pend && ready) begin
            m_pend = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 0; ready = 0; fetch = 0; rsp = 0; op1 = 0; op2 = 0; fpc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rv !== 1'b0)    begin errors++; $display("FAIL reset_valid got %0b exp 0", rv); end
        checks++; if (rpc !== 32'h0)  begin errors++; $display("FAIL reset_pc got %h exp 0", rpc); end
        checks++; if (ocnt !== 2'd0)  begin errors++; $display("FAIL reset_outs got %0d exp 0", ocnt); end
        checks++; if (drop !== 1'b0)  begin errors++; $display("FAIL reset_drop got %0b exp 0", drop); end
        checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL reset_ack got %0b exp 0", ack); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        advance();
        checks++; if (ack !== 1'b1)   begin errors++; $display("FAIL reset_ack_release got %0b exp 1", ack); end
        $display("reset: done");
    endtask

    task automatic test_basic();
        drive(1, 32'h8000_0100, 32'h0000_0020, 32'h0, 1, 0, 0);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack got %0b exp 1", ack); end
        checks++; if (sfb !== 1'b1) begin errors++; $display("FAIL basic_sfb got %0b exp 1", sfb); end
        advance();
        checks++; if (rv !== 1'b1)  begin errors++; $display("FAIL basic_valid got %0b exp 1", rv); end
        checks++; if (rpc !== 32'h8000_0120) begin errors++; $display("FAIL basic_pc got %h exp 80000120", rpc); end
        drive(0, 0, 0, 0, 1, 0, 0);
        advance();
        checks++; if (rv !== 1'b0)  begin errors++; $display("FAIL basic_valid_drop got %0b exp 0", rv); end
        $display("basic: redirect pc %h", rpc);
    endtask

    task automatic test_overwrite();
        int h0;
        h0 = dut_hsk;
        drive(1, 32'h100, 32'h0, 32'h0, 0, 0, 0);
        advance();
        checks++; if (rpc !== 32'h100) begin errors++; $display("FAIL ovw_pc1 got %h exp 100", rpc); end
        drive(0, 0, 0, 0, 0, 0, 0);
        advance();
        checks++; if (rpc !== 32'h100 || rv !== 1'b1) begin errors++; $display("FAIL ovw_hold got %h/%0b exp 100/1", rpc, rv); end
        drive(1, 32'h200, 32'h0, 32'h0, 0, 0, 0);
        advance();
        checks++; if (rpc !== 32'h200) begin errors++; $display("FAIL ovw_pc2 got %h exp 200", rpc); end
        drive(0, 0, 0, 0, 1, 0, 0);
        advance();
        drive(0, 0, 0, 0, 1, 0, 0);
        advance();
        checks++; if ((dut_hsk - h0) !== 1) begin errors++; $display("FAIL ovw_hsk got %0d exp 1", dut_hsk - h0); end
        $display("overwrite: handshakes %0d", dut_hsk - h0);
    endtask

    task automatic test_stale();
        drive(0, 0, 0, 0, 1, 1, 0); advance();
        drive(0, 0, 0, 0, 1, 1, 0); advance();
        checks++; if (ocnt !== 2'd2) begin errors++; $display("FAIL stale_outs got %0d exp 2", ocnt); end
        drive(1, 32'h300, 32'h0, 32'h0, 1, 0, 0);
        advance();
        drive(0, 0, 0, 0, 1, 1, 1);          // redirect fetch plus first response
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL stale_drop1 got %0b exp 1", drop); end
        advance();
        drive(0, 0, 0, 0, 1, 0, 1);
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL stale_drop2 got %0b exp 1", drop); end
        advance();
        drive(0, 0, 0, 0, 1, 0, 1);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL stale_drop3 got %0b exp 0", drop); end
        advance();
        checks++; if (ocnt !== 2'd0) begin errors++; $display("FAIL stale_outs_end got %0d exp 0", ocnt); end
        $display("stale: outstanding %0d", ocnt);
    endtask

    task automatic test_simul();
        drive(0, 0, 0, 0, 1, 1, 0); advance();
        drive(1, 32'h400, 32'h0, 32'h0, 0, 1, 1);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL simul_drop_pre got %0b exp 0", drop); end
        advance();
        checks++; if (ocnt !== 2'd1) begin errors++; $display("FAIL simul_outs got %0d exp 1", ocnt); end
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL simul_drop got %0b exp 1", drop); end
        drive(0, 0, 0, 0, 1, 0, 1);
        advance();
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL simul_drop_end got %0b exp 0", drop); end
        $display("simul: outstanding %0d", ocnt);
    endtask

    task automatic test_wrap();
        drive(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_1234, 1, 0, 0);
        advance();
        checks++; if (rpc !== 32'h0000_0004)   begin errors++; $display("FAIL wrap_pc got %h exp 00000004", rpc); end
        checks++; if (b_rpc !== 32'h0000_1234) begin errors++; $display("FAIL boost_pc got %h exp 00001234", b_rpc); end
        drive(0, 0, 0, 0, 1, 0, 0);
        advance();
        $display("wrap: pc %h boost pc %h", rpc, b_rpc);
    endtask

    task automatic test_random();
        int errs0;
        errs0 = errors;
        for (int i = 0; i < 400; i++) begin
            bit f, rdy, fh, rh;
            f   = ($urandom_range(0, 3) == 0);
            rdy = $urandom_range(0, 1) == 1;
            rh  = (q_ep.size() > 0) && ($urandom_range(0, 1) == 1);
            fh  = ((q_ep.size() < 2) || rh) && ($urandom_range(0, 1) == 1);
            drive(f, $urandom, $urandom, $urandom, rdy, fh, rh);
            checks++; if (drop !== exp_drop())   begin errors++; $display("FAIL rnd_drop cyc %0d got %0b exp %0b", i, drop, exp_drop()); end
            checks++; if (b_drop !== exp_drop()) begin errors++; $display("FAIL rnd_bdrop cyc %0d got %0b exp %0b", i, b_drop, exp_drop()); end
            checks++; if (sfb !== (f | m_pend))  begin errors++; $display("FAIL rnd_sfb cyc %0d got %0b exp %0b", i, sfb, f | m_pend); end
            advance();
            checks++; if (rv !== m_pend)         begin errors++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", i, rv, m_pend); end
            checks++; if (rpc !== m_pc)          begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, rpc, m_pc); end
            checks++; if (b_rpc !== m_bpc)       begin errors++; $display("FAIL rnd_bpc cyc %0d got %h exp %h", i, b_rpc, m_bpc); end
            checks++; if (ocnt !== 2'(q_ep.size())) begin errors++; $display("FAIL rnd_outs cyc %0d got %0d exp %0d", i, ocnt, q_ep.size()); end
        end
        $display("random: 400 cycles, new errors %0d", errors - errs0);
    endtask

    task automatic test_reset_mid();
        // drain anything left over from the random run
        while (q_ep.size() > 0) begin
            drive(0, 0, 0, 0, 1, 0, 1);
            advance();
        end
        drive(0, 0, 0, 0, 0, 1, 0); advance();
        drive(0, 0, 0, 0, 0, 1, 0); advance();
        drive(1, 32'h500, 32'h0, 32'h0, 0, 0, 0); advance();
        checks++; if (rv !== 1'b1 || drop !== 1'b1) begin errors++; $display("FAIL rstmid_setup got %0b/%0b exp 1/1", rv, drop); end
        @(negedge clk);
        req = 0; fetch = 0; rsp = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rv !== 1'b0)   begin errors++; $display("FAIL rstmid_valid got %0b exp 0", rv); end
        checks++; if (ocnt !== 2'd0) begin errors++; $display("FAIL rstmid_outs got %0d exp 0", ocnt); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %0b exp 0", drop); end
        checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL rstmid_ack got %0b exp 0", ack); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        advance();
        checks++; if (ack !== 1'b1 || rv !== 1'b0) begin errors++; $display("FAIL rstmid_release got %0b/%0b exp 1/0", ack, rv); end
        $display("reset_mid: done");
    endtask

    initial begin
        dut_hsk = 0;
        test_reset();
        test_basic();
        test_overwrite();
        test_stale();
        test_simul();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/e203_ifu_flush_rsp.md
Name: e203_ifu_flush_rsp

Overview:
- IFU-side responder for the EXU pipeline-flush interface.
- Accepts the flush request and its adder operands, and computes the redirect PC with the IFU adder (or takes a precomputed PC in timing-boost mode).
- Issues a single redirect fetch request toward the IFU fetch path.
- Tracks outstanding fetch transactions and marks stale responses (issued before a flush) for discard.

Parameters:
- PC_SIZE, 32, width of PC and adder operands
- OUTS_DEPTH, 2, max outstanding fetch transactions; counter width CNT_W = clog2(OUTS_DEPTH+1)
- TIMING_BOOST, 0, 1 = redirect PC taken from pipe_flush_pc, adder unused

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pipe_flush_req  in  1  flush request from EXU commit
- pipe_flush_ack  out  1  flush accepted
- pipe_flush_add_op1  in  PC_SIZE  redirect adder operand 1
- pipe_flush_add_op2  in  PC_SIZE  redirect adder operand 2
- pipe_flush_pc  in  PC_SIZE  precomputed redirect PC (used only when TIMING_BOOST=1)
- redir_valid  out  1  redirect fetch request pending
- redir_ready  in  1  fetch path accepts redirect
- redir_pc  out  PC_SIZE  redirect target
- seq_fetch_block  out  1  suppresses sequential fetch; = pipe_flush_req | redir_valid
- fetch_hsk  in  1  any fetch request (sequential or redirect) accepted by the bus this cycle
- rsp_hsk  in  1  fetch response accepted this cycle
- rsp_drop  out  1  current response is stale; consumer discards it
- outs_cnt  out  CNT_W  outstanding fetch count (debug/observability)

Behaviour:
- Reset values: redir_valid=0, redir_pc=0, outs_cnt=0, drop_cnt=0, rsp_drop=0. pipe_flush_ack=0 while rst_n low.
- pipe_flush_ack = 1 whenever out of reset.
  - A flush is always accepted in the cycle it is requested.
  - flush_hsk = pipe_flush_req & pipe_flush_ack.
- Target PC:
  - TIMING_BOOST=0: tgt = op1 + op2, modulo 2^PC_SIZE, carry discarded.
  - TIMING_BOOST=1: tgt = pipe_flush_pc.
- FSM, 2 states:
  - IDLE (redir_valid=0): on flush_hsk, redir_pc <= tgt and go to PEND. redir_valid rises the next cycle, so latency from flush to redirect is 1 cycle.
  - PEND (redir_valid=1): redir_pc held stable while redir_ready=0.
    - redir_valid & redir_ready with no flush_hsk: go to IDLE.
    - flush_hsk: redir_pc <= new tgt and stay in PEND. This applies even if redir_ready=1 in the same cycle: the old redirect is consumed and the new one is issued next cycle. The newest flush always wins.
- Outstanding counter: outs_cnt <= outs_cnt + fetch_hsk - rsp_hsk.
  - fetch_hsk=1 with outs_cnt==OUTS_DEPTH and rsp_hsk=0 is illegal (assertion).
  - rsp_hsk=1 with outs_cnt==0 is illegal (assertion).
- Drop counter (all transactions issued before or in the flush cycle are stale):
  - On flush_hsk: drop_cnt <= outs_cnt + fetch_hsk - rsp_hsk. A re-flush while drop_cnt>0 uses the same formula; the result subsumes the earlier stale entries.
  - Otherwise, on rsp_hsk & (drop_cnt!=0): drop_cnt decrements by 1.
  - rsp_drop = (drop_cnt != 0), combinational from the register. A response handshaking in the flush cycle itself is not dropped (it is already consumed).
- Redirect fetch: the fetch path asserts fetch_hsk for the redirect itself after flush. That transaction is never counted as stale.
- Reset mid-operation: all state clears asynchronously. A pending redirect is lost; EXU re-flushes as needed.

Decomposition:
- Shared package e203_ifu_pkg holds:
  - flush_st_e enum {IDLE, PEND}
  - CNT_W computation function
  - the OUTS_DEPTH default constant
- One natural sub-module: e203_ifu_outs_cnt, a saturating-checked up/down counter instantiated twice (outstanding and drop).
- Adder stays inline.

Test Plan:
- Basic redirect: TIMING_BOOST=0, flush with op1=0x8000_0100, op2=0x0000_0020, redir_ready=1 → ack same cycle; next cycle redir_valid=1, redir_pc=0x8000_0120; valid drops after the handshake.
- Backpressure and overwrite: redir_ready=0; flush tgt 0x100, then 2 cycles later flush tgt 0x200 → redir_pc stays 0x100 until the second flush, then 0x200; exactly one redirect handshake when ready rises.
- Stale discard: 2 fetches outstanding, flush with no same-cycle rsp → drop_cnt=2; next two responses have rsp_drop=1, the third (post-redirect) has rsp_drop=0.
- Simultaneous events: outs_cnt=1, flush with fetch_hsk=1 and rsp_hsk=1 in the same cycle → drop_cnt=1, outs_cnt=1.
- Adder wrap: op1=0xFFFF_FFFC, op2=0x8 → redir_pc=0x0000_0004. With TIMING_BOOST=1, pipe_flush_pc=0x1234 → redir_pc=0x1234 regardless of operands.
- Reset mid-PEND: assert rst_n=0 while redir_valid=1 and drop_cnt=2 → redir_valid, outs_cnt and rsp_drop are 0 immediately (asynchronous); after release, ack=1 and IDLE.
